systolic_west_skew_feeder: RTL
==============================

// Module: systolic_west_skew_feeder
// PURPOSE
//  Upstream feeder for the west edge of the int8 systolic PE array. Accepts one
//  ROWS-wide activation vector per handshake and buffers it in a small FIFO.
//  It skews each vector so that row r reaches its PE row r cycles after row 0.
//  Row 0 feeds i_west of the leftmost PE in that row.
//  Emits a per-row valid tag, and signals o_done when the last vector of a
//  tile has fully entered the array.
// PARAMETERS
//  ROWS   4  number of PE rows (lanes), >=1
//  DW     8  activation width per lane (int8)
//  DEPTH  4  input FIFO depth in vectors, power of 2, >=2
// PORTS
//  clk      in   1        rising-edge clock, the only clock
//  reset    in   1        asynchronous, active-low reset
//  i_valid  in   1        upstream vector valid
//  o_ready  out  1        feeder can accept a vector this cycle
//  i_data   in   ROWS*DW  vector; lane r = i_data[r*DW +: DW]
//  i_last   in   1        marks the final vector of a tile (qualified by i_valid)
//  o_west   out  ROWS*DW  skewed activations; lane r drives PE row r i_west
//  o_vld    out  ROWS     per-lane valid tag aligned with o_west
//  o_busy   out  1        state != IDLE
//  o_done   out  1        one-cycle pulse: last vector fully skewed out
// BEHAVIOUR
//  Reset (reset==0, async) clears the FIFO pointers, all skew registers, o_west,
//   o_vld, o_done and o_busy to 0, and puts the FSM in IDLE. o_ready is 1 after
//   reset. Reset asserted mid-tile aborts the tile with no o_done.
//  Accept occurs when i_valid && o_ready at a rising edge; the vector and
//   i_last are written to the FIFO.
//  o_ready = !fifo_full && (state==IDLE || state==STREAM).
//  Pop: at every edge where the FIFO is non-empty, the head is popped into the
//   lane-0 stage. Push and pop in the same edge are legal; the count is
//   unchanged.
//  FIFO empty at an edge: a bubble enters lane 0 (data 0, vld 0).
//  Skew: the lane-r input stage feeds a chain of r registers.
//   A vector popped at edge p appears on o_west/o_vld lane r after edge p+r.
//   Lane 0 shows it after edge p.
//  Latency: a vector accepted into an empty FIFO at edge k is popped at edge
//   k+1, so lane r shows it after edge k+1+r.
//  o_west lanes with vld=0 are forced to 0, so PE accumulation is unaffected.
//  FSM:
//   IDLE   -> STREAM on an accept without i_last;
//             -> FLUSH on an accept with i_last.
//   STREAM -> FLUSH on an accept with i_last.
//   FLUSH  o_ready=0; the FIFO keeps popping.
//          -> DRAIN at the edge p that pops the last-tagged entry.
//          cnt loads ROWS-1 at that edge.
//   DRAIN  o_ready=0; cnt decrements each edge.
//          -> IDLE at the edge where cnt==0, i.e. edge p+ROWS-1.
//          o_done=1 for exactly the cycle following that edge.
//  ROWS==1: FLUSH -> IDLE directly at edge p, with o_done following edge p.
//  Bubbles are never inserted mid-tile if the FIFO holds data; upstream stalls
//   only delay the tile.
//  Arithmetic: no arithmetic is performed; data passes bit-exact (signed int8
//   is treated as opaque).
//  Full: with DEPTH entries, o_ready=0; i_valid is ignored and no overwrite
//   occurs.
//  Pointers wrap modulo DEPTH. The count is held in log2(DEPTH)+1 bits.
// TESTING
//  T1 reset: drive reset=0 mid-stream -> all outputs 0 immediately, o_ready=1
//   after release, and no o_done.
//  T2 single vector {4,3,2,1} (lane0=1) with i_last, accepted at edge 0 ->
//   lane0=1 after edge1, lane1=2 after edge2, lane2=3 after edge3,
//   lane3=4 after edge4.
//   o_done after edge 4; o_busy 1 during edges 0..4.
//  T3 back-to-back 6 vectors, the 6th with last, i_valid held 1 -> no bubbles
//   (o_vld lane0 high 6 consecutive cycles); o_done exactly 1 pulse.
//  T4 backpressure: i_valid held, no pop path stalled via reset-free bubble
//   test; fill 4 vectors in 4 cycles while pop runs -> count never exceeds
//   DEPTH; o_ready never low with push/pop balanced.
//  T5 gaps: i_valid toggles 1,0,1 -> a bubble in lane 0 (data 0, vld 0) that
//   propagates diagonally, appearing on lane r one cycle later per r.
//  T6 last in FLUSH: i_valid held 1 after the last is accepted -> o_ready=0
//   until o_done; the next vector is accepted the cycle after o_done.

Source files
------------

// File: rtl/systolic_west_skew_feeder.sv
// West-edge activation feeder for the int8 systolic array: small input FIFO,
// per-lane diagonal skew, and a tile FSM that pulses o_done once the last vector has fully entered.
module systolic_west_skew_feeder #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ROWS*DW-1:0] i_data,
  input  logic               i_last,
  output logic [ROWS*DW-1:0] o_west,
  output logic [ROWS-1:0]    o_vld,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_e;

  logic [ROWS*DW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   last_q;
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        fill_q, fill_d;
  state_e             state_q;
  logic [CW-1:0]      drain_q;
  logic               done_q;

  logic accept, pop, pop_last, full;

  assign full     = (fill_q == FULL_CNT);
  assign o_ready  = !full && (state_q == IDLE || state_q == STREAM);
  assign accept   = i_valid && o_ready;
  assign pop      = (fill_q != '0);
  assign pop_last = pop && last_q[rd_q];
  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_q]  <= i_data;
      last_q[wr_q] <= i_last;
    end
  end

  always_comb begin
    fill_d = fill_q;
    case ({accept, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      fill_q <= fill_d;
    end
  end

  // Lane r: one input stage fed by the FIFO head plus r delay registers.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0][DW-1:0] d_q;
    logic [r:0]         v_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= pop ? mem_q[rd_q][r*DW +: DW] : '0;
        v_q[0] <= pop;
        for (int unsigned k = 1; k <= r; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign o_west[r*DW +: DW] = v_q[r] ? d_q[r] : '0;
    assign o_vld[r]           = v_q[r];
  end

  // DRAIN leaves when the counter would reach zero, giving IDLE at edge p+ROWS-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) state_q <= i_last ? FLUSH : STREAM;
        end
        STREAM: begin
          if (accept && i_last) state_q <= FLUSH;
        end
        FLUSH: begin
          if (pop_last) begin
            if (ROWS == 1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              drain_q <= CW'(ROWS - 1);
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q - 1'b1;
          if (drain_q == CW'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
